// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one shift per clock)
// feeding per-digit 7-segment decoders, with a registered leading-zero blank mask.
module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      bin,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank,
   output logic                  busy
);

   localparam int WW = 4*DIGITS + WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PW = WIDTH + 4*DIGITS + 4;
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

   // True when DIGITS decimal digits can hold every WIDTH-bit value.
   function automatic bit digits_ok();
      logic [PW-1:0] p;
      logic [PW-1:0] lim;
      p   = PW'(1);
      lim = '0;
      lim[WIDTH] = 1'b1;
      for (int i = 0; i < DIGITS; i++) p = p * PW'(10);
      return p >= lim;
   endfunction

   if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "bin2bcd_seq: WIDTH must be >= 1");
   end
   if (!digits_ok()) begin : g_bad_digits
      $fatal(1, "bin2bcd_seq: DIGITS too small for WIDTH");
   end

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t               state_q, state_d;
   logic [WW-1:0]        work_q, work_d;
   logic [CW-1:0]        count_q, count_d;
   logic [4*DIGITS-1:0]  bcd_q, bcd_d;
   logic [DIGITS-1:0]    blank_q, blank_d;
   logic                 out_valid_q, out_valid_d;

   logic [WW-1:0]        adj;
   logic [WW-1:0]        shifted;
   logic [4*DIGITS-1:0]  final_bcd;
   logic [DIGITS-1:0]    final_blank;
   logic                 all_zero;

   assign in_ready  = (state_q == IDLE) && rst_n;
   assign busy      = (state_q == SHIFT);
   assign out_valid = out_valid_q;
   assign bcd       = bcd_q;
   assign blank     = blank_q;

   // One double-dabble step, plus the result and blank mask it would commit.
   always_comb begin
      adj = work_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (adj[WIDTH+4*d +: 4] >= 4'd5)
            adj[WIDTH+4*d +: 4] = adj[WIDTH+4*d +: 4] + 4'd3;
      end
      shifted   = {adj[WW-2:0], 1'b0};
      final_bcd = shifted[WW-1 -: 4*DIGITS];

      final_blank = '0;
      all_zero    = 1'b1;
      for (int i = DIGITS-1; i > 0; i--) begin
         all_zero       = all_zero && (final_bcd[4*i +: 4] == 4'd0);
         final_blank[i] = all_zero;
      end
   end

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      count_d     = count_q;
      bcd_d       = bcd_q;
      blank_d     = blank_q;
      out_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               work_d  = {{(4*DIGITS){1'b0}}, bin};
               count_d = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            work_d  = shifted;
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH-1)) begin
               bcd_d       = final_bcd;
               blank_d     = final_blank;
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         work_q      <= '0;
         count_q     <= '0;
         bcd_q       <= '0;
         blank_q     <= BLANK_RST;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         count_q     <= count_d;
         bcd_q       <= bcd_d;
         blank_q     <= blank_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: 8-bit/3-digit and 16-bit/5-digit instances checked
// against a decimal arithmetic reference model.
module tb_bin2bcd_seq;

   logic        clk;
   logic        rst_n;

   logic        in_valid8;
   logic        in_ready8;
   logic [7:0]  bin8;
   logic        out_valid8;
   logic [11:0] bcd8;
   logic [2:0]  blank8;
   logic        busy8;

   logic        in_valid16;
   logic        in_ready16;
   logic [15:0] bin16;
   logic        out_valid16;
   logic [19:0] bcd16;
   logic [4:0]  blank16;
   logic        busy16;

   int tests_run;
   int tests_failed;

   bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .bin(bin8), .out_valid(out_valid8), .bcd(bcd8), .blank(blank8), .busy(busy8)
   );

   bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .bin(bin16), .out_valid(out_valid16), .bcd(bcd16), .blank(blank16), .busy(busy16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decimal digits of v, units in the low nibble.
   function automatic logic [19:0] model_bcd(input int unsigned v, input int digits);
      logic [19:0] r;
      r = '0;
      for (int i = 0; i < digits; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Digit i is blank when i > 0 and v has fewer than i+1 decimal digits.
   function automatic logic [4:0] model_blank(input int unsigned v, input int digits);
      logic [4:0] r;
      int unsigned p;
      r = '0;
      p = 1;
      for (int i = 1; i < digits; i++) begin
         p = p * 10;
         r[i] = (v < p);
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic convert8(input int unsigned v, output int edges,
                           output logic [11:0] b, output logic [2:0] bl);
      int waits;
      waits = 0;
      while (!in_ready8 && waits < 40) begin
         tick();
         waits++;
      end
      in_valid8 = 1'b1;
      bin8      = 8'(v);
      tick();
      in_valid8 = 1'b0;
      bin8      = 8'($urandom);
      edges = -1;
      b     = 'x;
      bl    = 'x;
      for (int e = 1; e <= 40; e++) begin
         tick();
         if (out_valid8) begin
            edges = e;
            b     = bcd8;
            bl    = blank8;
            break;
         end
      end
   endtask

   task automatic convert16(input int unsigned v, output int edges,
                            output logic [19:0] b, output logic [4:0] bl);
      int waits;
      waits = 0;
      while (!in_ready16 && waits < 40) begin
         tick();
         waits++;
      end
      in_valid16 = 1'b1;
      bin16      = 16'(v);
      tick();
      in_valid16 = 1'b0;
      edges = -1;
      b     = 'x;
      bl    = 'x;
      for (int e = 1; e <= 60; e++) begin
         tick();
         if (out_valid16) begin
            edges = e;
            b     = bcd16;
            bl    = blank16;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (in_ready8 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_in_ready_low: got %b want 0", in_ready8);
      end
      tick();
      tick();
      tests_run++;
      if (bcd8 !== 12'h000 || blank8 !== 3'b110 || out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got bcd=%h blank=%b ov=%b busy=%b want 000 110 0 0",
                  bcd8, blank8, out_valid8, busy8);
      end
      tests_run++;
      if (bcd16 !== 20'h00000 || blank16 !== 5'b11110) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs16: got bcd=%h blank=%b want 00000 11110", bcd16, blank16);
      end
      rst_n = 1'b1;
      #1;
      tests_run++;
      if (in_ready8 !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_release_ready: got %b want 1", in_ready8);
      end
   endtask

   task automatic test_directed();
      int unsigned vals[5] = '{0, 255, 9, 100, 47};
      int edges;
      logic [11:0] b;
      logic [2:0] bl;
      foreach (vals[k]) begin
         convert8(vals[k], edges, b, bl);
         tests_run++;
         if (edges != 8) begin
            tests_failed++;
            $display("[TB] FAIL latency_%0d: got %0d edges want 8", vals[k], edges);
         end
         tests_run++;
         if (b !== model_bcd(vals[k], 3)[11:0] || bl !== model_blank(vals[k], 3)[2:0]) begin
            tests_failed++;
            $display("[TB] FAIL convert_%0d: got bcd=%h blank=%b want bcd=%h blank=%b",
                     vals[k], b, bl, model_bcd(vals[k], 3)[11:0], model_blank(vals[k], 3)[2:0]);
         end
         tick();
         tests_run++;
         if (out_valid8 !== 1'b0 || bcd8 !== b) begin
            tests_failed++;
            $display("[TB] FAIL pulse_hold_%0d: got ov=%b bcd=%h want ov=0 bcd=%h",
                     vals[k], out_valid8, bcd8, b);
         end
      end
   endtask

   task automatic test_random();
      int unsigned v;
      int edges;
      logic [11:0] b;
      logic [2:0] bl;
      for (int k = 0; k < 20; k++) begin
         v = $urandom_range(0, 255);
         convert8(v, edges, b, bl);
         tests_run++;
         if (edges != 8 || b !== model_bcd(v, 3)[11:0] || bl !== model_blank(v, 3)[2:0]) begin
            tests_failed++;
            $display("[TB] FAIL random_%0d: got edges=%0d bcd=%h blank=%b want 8 %h %b",
                     v, edges, b, bl, model_bcd(v, 3)[11:0], model_blank(v, 3)[2:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lows, t1, t2;
      logic [11:0] b1, b2;
      lows = 0; t1 = -1; t2 = -1; b1 = 'x; b2 = 'x;
      in_valid8 = 1'b1;
      bin8      = 8'd200;
      tick();
      bin8 = 8'd13;
      for (int t = 0; t < 25; t++) begin
         if (t > 0) tick();
         if (t < 18 && !in_ready8) lows++;
         if (out_valid8) begin
            if (t1 < 0) begin
               t1 = t; b1 = bcd8;
            end else if (t2 < 0) begin
               t2 = t; b2 = bcd8;
            end
         end
         if (t == 9) in_valid8 = 1'b0;
      end
      tests_run++;
      if (t1 != 8 || t2 != 17) begin
         tests_failed++;
         $display("[TB] FAIL b2b_timing: got pulses at %0d,%0d want 8,17", t1, t2);
      end
      tests_run++;
      if (b1 !== 12'h200 || b2 !== 12'h013) begin
         tests_failed++;
         $display("[TB] FAIL b2b_values: got %h,%h want 200,013", b1, b2);
      end
      tests_run++;
      if (lows != 16) begin
         tests_failed++;
         $display("[TB] FAIL b2b_ready_low: got %0d low cycles want 16", lows);
      end
   endtask

   task automatic test_interference();
      int pulses;
      logic [11:0] b;
      pulses = 0; b = 'x;
      in_valid8 = 1'b1;
      bin8      = 8'd150;
      tick();
      for (int t = 0; t < 20; t++) begin
         if (t > 0) tick();
         if (t < 6) begin
            in_valid8 = t[0];
            bin8      = 8'($urandom);
         end else begin
            in_valid8 = 1'b0;
         end
         if (out_valid8) begin
            pulses++;
            b = bcd8;
         end
      end
      tests_run++;
      if (pulses != 1 || b !== 12'h150) begin
         tests_failed++;
         $display("[TB] FAIL interference: got pulses=%0d bcd=%h want 1 150", pulses, b);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      pulses = 0;
      in_valid8 = 1'b1;
      bin8      = 8'd123;
      tick();
      in_valid8 = 1'b0;
      for (int t = 0; t < 4; t++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      tests_run++;
      if (bcd8 !== 12'h000 || blank8 !== 3'b110 || out_valid8 !== 1'b0 || busy8 !== 1'b0
          || in_ready8 !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_state: got bcd=%h blank=%b ov=%b busy=%b rdy=%b want 000 110 0 0 1",
                  bcd8, blank8, out_valid8, busy8, in_ready8);
      end
      for (int t = 0; t < 12; t++) begin
         tick();
         if (out_valid8) pulses++;
      end
      tests_run++;
      if (pulses != 0) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_no_pulse: got %0d pulses want 0", pulses);
      end
   endtask

   task automatic test_wide();
      int unsigned vals[6];
      int edges;
      logic [19:0] b;
      logic [4:0] bl;
      vals[0] = 65535;
      vals[1] = 1;
      for (int k = 2; k < 6; k++) vals[k] = $urandom_range(0, 65535);
      foreach (vals[k]) begin
         convert16(vals[k], edges, b, bl);
         tests_run++;
         if (edges != 16 || b !== model_bcd(vals[k], 5) || bl !== model_blank(vals[k], 5)) begin
            tests_failed++;
            $display("[TB] FAIL wide_%0d: got edges=%0d bcd=%h blank=%b want 16 %h %b",
                     vals[k], edges, b, bl, model_bcd(vals[k], 5), model_blank(vals[k], 5));
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      in_valid8    = 1'b0;
      bin8         = '0;
      in_valid16   = 1'b0;
      bin16        = '0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_interference();
      test_reset_mid();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one shift per clock. It sits directly upstream of the per-digit 7-segment decoders. It converts controller data bytes (e.g. analog stick 0–255) into decimal digit nibbles. It also produces a leading-zero blank mask, so the display shows decimal values instead of hex.

Parameters:
WIDTH, 8, bit width of the binary input; must be >= 1.
DIGITS, 3, number of BCD output digits; elaboration must fail (assertion) if 10^DIGITS <= 2^WIDTH - 1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  binary value on bin is offered
in_ready  output  1  block can accept a value (IDLE)
bin  input  WIDTH  unsigned binary value, sampled only on accept
out_valid  output  1  one-cycle pulse: bcd/blank just updated
bcd  output  4*DIGITS  digit i at bits [4i+3:4i], digit 0 = units; each nibble 0..9; held between conversions
blank  output  DIGITS  blank[i]=1: digit i is a leading zero and should be driven dark; blank[0] always 0
busy  output  1  conversion in progress (state SHIFT)

Behaviour:
- Reset (rst_n=0 at a rising edge) puts the block in this state:
  - state=IDLE, shift/count registers cleared.
  - bcd=0, blank={DIGITS-1 ones, 0} so only "0" is shown, out_valid=0, busy=0.
  - in_ready=0 combinationally while rst_n=0.
- States: IDLE, SHIFT.
- in_ready = (state==IDLE) && rst_n; busy = (state==SHIFT).
- Accept edge (E0): rising edge with in_valid && in_ready.
  - bin loads into the low WIDTH bits of the working register.
  - BCD scratch is cleared, count=0, state -> SHIFT.
- SHIFT, one step per edge (E1..E_WIDTH):
  - Every scratch digit >= 5 gets +3 (combinational).
  - The whole {scratch, binary} register then shifts left by 1; count increments.
- At edge E_WIDTH (count==WIDTH-1 before the edge), the following happen together:
  - The final scratch digits are loaded into bcd and blank is computed from them.
  - out_valid=1 for exactly that one cycle; state -> IDLE.
- Latency: out_valid is high in the cycle after edge E_WIDTH, i.e. WIDTH cycles after accept.
- A new accept may occur in the cycle where out_valid is high, so the period is WIDTH+1 cycles.
- blank[i] = 1 iff i>0 and digits i..DIGITS-1 of the new result are all zero. It is registered alongside bcd.
- in_valid during SHIFT is ignored: no queuing, no effect on the current conversion.
  - The upstream must hold in_valid until in_ready is seen.
- Changes to bin after the accept edge do not affect the result.
- bcd/blank change only at a completion edge or at reset. They are never partially updated.
- Reset mid-conversion: conversion is aborted, no out_valid is produced, and outputs return to their reset values.
- Arithmetic:
  - Working register is 4*DIGITS+WIDTH bits.
  - Add-3 is per-nibble with no carry between nibbles; the digit < 10 invariant guarantees no overflow.
  - Unused upper digits stay 0.

Test Plan:
- WIDTH=8, DIGITS=3:
  - Reset, then bin=0 accepted -> out_valid after 8 cycles; bcd=12'h000, blank=3'b110.
  - Reset alone gives the same bcd and blank, with out_valid=0.
- bin=255 -> bcd=12'h255, blank=3'b000.
- bin=9 -> bcd=12'h009, blank=3'b110.
- bin=100 -> bcd=12'h100, blank=3'b000.
- bin=47 -> bcd=12'h047, blank=3'b100.
- Back-to-back, in_valid held high with bin=200 then 13 -> in_ready low for 8 cycles after each accept.
  - out_valid pulses 9 cycles apart: first bcd=12'h200, then 12'h013.
- Interference during a conversion:
  - bin changed and in_valid toggled mid-conversion -> result matches the originally accepted value; exactly one out_valid.
  - rst_n=0 at step 4 of converting 123 -> no out_valid; bcd=0, blank=3'b110, in_ready=1 after reset release.
- WIDTH=16, DIGITS=5:
  - bin=65535 -> bcd=20'h65535 after 16 cycles.
  - bin=1 -> bcd=20'h00001, blank=5'b11110.
